// File: rtl/seq_counter_param.sv
// Table-driven sequence counter: steps an index through a writable value table, updating on the
// falling clock edge. Define SEQCNT_REVERSE_EN to add the dir port and reverse stepping.
module seq_counter_param #(
    parameter  int unsigned WIDTH = 4,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
`ifdef SEQCNT_REVERSE_EN
    input  logic             dir,
`endif
    input  logic             len_wr,
    input  logic [AW-1:0]    len_in,
    input  logic             tbl_we,
    input  logic [AW-1:0]    tbl_addr,
    input  logic [WIDTH-1:0] tbl_din,
    output logic [WIDTH-1:0] out,
    output logic [AW-1:0]    idx,
    output logic             wrap
);

    localparam logic [AW-1:0] LastMax = AW'(DEPTH - 1);

    logic [WIDTH-1:0] r_table [DEPTH];
    logic [AW-1:0]    r_last;
    logic [AW-1:0]    r_idx;
    logic [WIDTH-1:0] r_out;
    logic             r_wrap;

    logic             w_addr_ok;
    logic [AW-1:0]    w_last_new;
    logic [AW-1:0]    w_last_nxt;
    logic [AW-1:0]    w_idx_nxt;
    logic             w_wrap_nxt;
    logic [WIDTH-1:0] w_out_nxt;

    // Compare at 32 bits so non-power-of-two depths range-check correctly.
    assign w_addr_ok  = 32'(tbl_addr) < DEPTH;
    assign w_last_new = (32'(len_in) > (DEPTH - 1)) ? LastMax : len_in;

    always_comb begin
        w_last_nxt = r_last;
        w_idx_nxt  = r_idx;
        w_wrap_nxt = 1'b0;
        if (len_wr) begin
            w_last_nxt = w_last_new;
            if (r_idx > w_last_new) begin
                w_idx_nxt = '0;
            end
        end else if (en) begin
`ifdef SEQCNT_REVERSE_EN
            if (dir) begin
                if (r_idx == '0) begin
                    w_idx_nxt  = r_last;
                    w_wrap_nxt = 1'b1;
                end else begin
                    w_idx_nxt = r_idx - 1'b1;
                end
            end else
`endif
            begin
                if (r_idx == r_last) begin
                    w_idx_nxt  = '0;
                    w_wrap_nxt = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
        end
    end

    // A same-edge write to the entry being selected is forwarded straight to out.
    always_comb begin
        w_out_nxt = r_table[w_idx_nxt];
        if (tbl_we && w_addr_ok && (tbl_addr == w_idx_nxt)) begin
            w_out_nxt = tbl_din;
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_table[i] <= WIDTH'(i);
            end
            r_last <= LastMax;
            r_idx  <= '0;
            r_out  <= '0;
            r_wrap <= 1'b0;
        end else begin
            if (tbl_we && w_addr_ok) begin
                r_table[tbl_addr] <= tbl_din;
            end
            r_last <= w_last_nxt;
            r_idx  <= w_idx_nxt;
            r_out  <= w_out_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign out  = r_out;
    assign idx  = r_idx;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_seq_counter_param.sv
// Directed bench for seq_counter_param (WIDTH=4, DEPTH=16); reverse checks only when
// SEQCNT_REVERSE_EN is defined.
module tb_seq_counter_param;

    logic       clk;
    logic       rst;
    logic       en;
`ifdef SEQCNT_REVERSE_EN
    logic       dir;
`endif
    logic       len_wr;
    logic [3:0] len_in;
    logic       tbl_we;
    logic [3:0] tbl_addr;
    logic [3:0] tbl_din;
    logic [3:0] out;
    logic [3:0] idx;
    logic       wrap;

    int n_checks = 0;
    int n_fail   = 0;

    seq_counter_param #(
        .WIDTH(4),
        .DEPTH(16)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
`ifdef SEQCNT_REVERSE_EN
        .dir     (dir),
`endif
        .len_wr  (len_wr),
        .len_in  (len_in),
        .tbl_we  (tbl_we),
        .tbl_addr(tbl_addr),
        .tbl_din (tbl_din),
        .out     (out),
        .idx     (idx),
        .wrap    (wrap)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance past one active (falling) edge and settle.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en       = 1'b0;
        len_wr   = 1'b0;
        len_in   = '0;
        tbl_we   = 1'b0;
        tbl_addr = '0;
        tbl_din  = '0;
`ifdef SEQCNT_REVERSE_EN
        dir      = 1'b0;
`endif
    endtask

    task automatic write_entry(input logic [3:0] a, input logic [3:0] d);
        tbl_we   = 1'b1;
        tbl_addr = a;
        tbl_din  = d;
        tick();
        tbl_we   = 1'b0;
    endtask

    logic [3:0] exp_seq [8];

    initial begin
        idle_inputs();
        rst = 1'b0;
        #1;
        check_eq("rst_out", 32'(out), 32'd0);
        check_eq("rst_idx", 32'(idx), 32'd0);
        check_eq("rst_wrap", 32'(wrap), 32'd0);
        @(posedge clk);
        rst = 1'b1;

        // Full forward sweep over the identity table.
        en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check_eq("sweep_out", 32'(out), 32'(k % 16));
            check_eq("sweep_wrap", 32'(wrap), (k == 16) ? 32'd1 : 32'd0);
        end
        check_eq("sweep_idx", 32'(idx), 32'd0);

        // Reprogram table head and shorten the sequence to 4 entries.
        en = 1'b0;
        write_entry(4'd0, 4'd1);
        check_eq("fwd_write_out", 32'(out), 32'd1);
        check_eq("hold_idx", 32'(idx), 32'd0);
        write_entry(4'd1, 4'd3);
        write_entry(4'd2, 4'd5);
        write_entry(4'd3, 4'd0);
        len_wr = 1'b1;
        len_in = 4'd3;
        tick();
        len_wr = 1'b0;
        check_eq("len_idx_hold", 32'(idx), 32'd0);
        exp_seq = '{4'd3, 4'd5, 4'd0, 4'd1, 4'd3, 4'd5, 4'd0, 4'd1};
        en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_eq("short_out", 32'(out), 32'(exp_seq[k]));
            check_eq("short_wrap", 32'(wrap), (k == 3 || k == 7) ? 32'd1 : 32'd0);
        end

        // Restore full length, run to idx 10, then shrink below idx with en also high.
        en     = 1'b0;
        len_wr = 1'b1;
        len_in = 4'd15;
        tick();
        len_wr = 1'b0;
        en     = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        check_eq("run10_idx", 32'(idx), 32'd10);
        check_eq("run10_out", 32'(out), 32'd10);
        len_wr = 1'b1;
        len_in = 4'd5;
        tick();
        len_wr = 1'b0;
        check_eq("shrink_idx", 32'(idx), 32'd0);
        check_eq("shrink_out", 32'(out), 32'd1);
        check_eq("shrink_wrap", 32'(wrap), 32'd0);
        for (int k = 0; k < 5; k++) tick();
        check_eq("len5_idx", 32'(idx), 32'd5);
        check_eq("len5_wrap", 32'(wrap), 32'd0);
        tick();
        check_eq("len5_wrap_idx", 32'(idx), 32'd0);
        check_eq("len5_wrap_pulse", 32'(wrap), 32'd1);
        check_eq("len5_wrap_out", 32'(out), 32'd1);

        // Same-edge write to the next index is forwarded.
        tick();
        tick();
        check_eq("pre_fwd_idx", 32'(idx), 32'd2);
        tbl_we   = 1'b1;
        tbl_addr = 4'd3;
        tbl_din  = 4'hA;
        tick();
        tbl_we = 1'b0;
        check_eq("fwd_idx", 32'(idx), 32'd3);
        check_eq("fwd_out", 32'(out), 32'hA);
        en = 1'b0;
        tick();
        check_eq("en0_idx", 32'(idx), 32'd3);
        check_eq("en0_out", 32'(out), 32'hA);
        check_eq("en0_wrap", 32'(wrap), 32'd0);

        // Asynchronous reset between edges.
        en = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check_eq("async_out", 32'(out), 32'd0);
        check_eq("async_idx", 32'(idx), 32'd0);
        check_eq("async_wrap", 32'(wrap), 32'd0);
        // Edge while held in reset: advance and write must be discarded.
        tbl_we   = 1'b1;
        tbl_addr = 4'd1;
        tbl_din  = 4'hF;
        tick();
        check_eq("inrst_idx", 32'(idx), 32'd0);
        check_eq("inrst_out", 32'(out), 32'd0);
        #2;
        rst    = 1'b1;
        tbl_we = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_eq("post_rst_out", 32'(out), 32'(k));
        end
        for (int k = 4; k <= 16; k++) tick();
        check_eq("post_rst_last", 32'(idx), 32'd0);
        check_eq("post_rst_lastw", 32'(wrap), 32'd1);

`ifdef SEQCNT_REVERSE_EN
        en = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        rst = 1'b1;
        dir = 1'b1;
        en  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("rev_idx", 32'(idx), 32'(15 - k));
            check_eq("rev_out", 32'(out), 32'(15 - k));
            check_eq("rev_wrap", 32'(wrap), (k == 0) ? 32'd1 : 32'd0);
        end
        dir = 1'b0;
        tick();
        check_eq("dir_flip_idx", 32'(idx), 32'd14);
`endif

        idle_inputs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/seq_counter_param.md
SEQ_COUNTER_PARAM -- requirements
Module: seq_counter_param

Interface
REQ-001 Parameter WIDTH, default 4: bit width of each sequence value and of out.
REQ-002 Parameter DEPTH, default 16: number of sequence table entries, minimum 2; AW = ceil(log2(DEPTH)) is derived, not overridable.
REQ-003 clk  input  1  single clock; all state updates on the falling edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  advance the sequence index on this edge.
REQ-006 dir  input  1  0 = forward, 1 = reverse; port exists only when SEQCNT_REVERSE_EN is defined.
REQ-007 len_wr  input  1  load the last-index register from len_in.
REQ-008 len_in  input  AW  new last index.
REQ-009 tbl_we  input  1  write tbl_din into table[tbl_addr].
REQ-010 tbl_addr  input  AW  table write address.
REQ-011 tbl_din  input  WIDTH  table write data.
REQ-012 out  output  WIDTH  registered sequence value, table[idx].
REQ-013 idx  output  AW  registered current table index.
REQ-014 wrap  output  1  registered one-edge pulse, sequence wrapped.

Function
REQ-015 The block SHALL hold a DEPTH x WIDTH register table, a last-index register `last`, the index register idx, and the output registers out and wrap.
REQ-016 Table writes SHALL occur on any falling edge with tbl_we=1, independent of en and len_wr; a write with tbl_addr >= DEPTH SHALL be ignored.
REQ-017 With len_wr=1, `last` SHALL take len_in, saturated to DEPTH-1.
  - If idx > new last, idx SHALL become 0; otherwise idx holds.
  - en SHALL be ignored on that edge, and wrap SHALL be 0.
REQ-018 With len_wr=0 and en=1 in forward mode:
  - idx SHALL become 0 if idx == last, else idx+1.
  - wrap SHALL be 1 exactly when idx == last before the edge.
REQ-019 With len_wr=0 and en=1 in reverse mode:
  - idx SHALL become last if idx == 0, else idx-1.
  - wrap SHALL be 1 exactly when idx == 0 before the edge.
REQ-020 With len_wr=0 and en=0, idx SHALL hold and wrap SHALL be 0.
REQ-021 On every falling edge, out SHALL take table[new idx], using the post-write table contents. A same-edge tbl_we to the new idx is forwarded, so latency is one edge.
REQ-022 A dir change SHALL take effect on the same edge it is sampled, with no extra latency.

Reset
REQ-023 While rst=0, the following SHALL be asynchronous and immediate:
  - table[i] = i mod 2^WIDTH
  - last = DEPTH-1
  - idx = 0, out = 0, wrap = 0
REQ-024 Reset assertion mid-operation SHALL discard any in-flight write, length load or advance on that edge.
REQ-025 The first falling edge after rst rises SHALL be processed normally.

Configuration
REQ-026 Macro SEQCNT_REVERSE_EN:
  - Defined: the dir port exists and REQ-019 applies when dir=1.
  - Undefined: no dir port, forward-only operation, no reverse logic synthesised.

Verification (WIDTH=4, DEPTH=16)
REQ-027 Reset then 16 edges with en=1 -> out 1,2,...,15,0; wrap=1 only after the 16th edge; idx=0.
REQ-028 Write table[0..3]=1,3,5,0 with en=0, then len_wr with len_in=3, then 8 edges with en=1 -> out 3,5,0,1,3,5,0,1; wrap after the 4th and 8th edges.
REQ-029 idx=10, len_wr with len_in=5 and en=1 on the same edge -> idx=0, out=table[0], wrap=0; subsequent advance wraps after idx 5.
REQ-030 (SEQCNT_REVERSE_EN) Identity table, last=15, idx=0, dir=1, en=1 -> idx 15,14,13; wrap=1 on the first edge only. dir=0 on the next edge -> idx 14.
REQ-031 idx=2, tbl_we to address 3 with data 0xA and en=1 on the same edge -> out=0xA on that edge.
REQ-032 rst pulsed low between edges mid-run -> out=0, idx=0, wrap=0 immediately; table returns to identity.
